norm_round: RTL and testbench

Post-processing stage of the single-precision floating-point multiplier. It sits directly downstream of the exponent adder and the mantissa multiplier. It takes the raw 9-bit exponent sum, the 48-bit mantissa product and the result sign, then removes the bias, normalizes, rounds to nearest-even and packs an IEEE-754 word. The block is a multi-cycle FSM with a valid/ready handshake on both sides.

---
 rtl/norm_round.sv | 200 ++++++++++++++++++++
 tb/tb_norm_round.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_round.sv
// norm_round: post-processing stage of the single-precision FP multiplier.
// Removes the exponent bias, normalizes the 48-bit mantissa product, rounds
// to nearest-even and packs an IEEE-754 word. Multi-cycle FSM:
// IDLE -> NORM -> ROUND -> PACK -> OUT -> IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   upstream operand set valid
//   in_ready   out  high only in IDLE (decoded from state register)
//   sign_in    in   result sign
//   exp_sum    in   [8:0]  sum of the two biased exponents
//   mant_prod  in   [47:0] product of the 24-bit mantissas (implicit 1s)
//   out_valid  out  result valid, held until accepted
//   out_ready  in   downstream accepts result
//   result     out  [31:0] packed float {sign, exp, frac}
//   overflow   out  result saturated to infinity (qualified by out_valid)
//   underflow  out  result flushed to zero (qualified by out_valid)
module norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [8:0]  exp_sum,
  input  logic [47:0] mant_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StNorm  = 3'd1;
  localparam logic [2:0] StRound = 3'd2;
  localparam logic [2:0] StPack  = 3'd3;
  localparam logic [2:0] StOut   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;

  // Captured operands
  logic              r_sign;
  logic [8:0]        r_exp_sum;
  logic [47:0]       r_mant;

  // Normalized / rounded intermediate values
  logic              r_zero;
  logic [22:0]       r_frac;
  logic              r_guard;
  logic              r_sticky;
  logic signed [9:0] r_e;

  // Registered outputs
  logic              r_out_valid;
  logic [31:0]       r_result;
  logic              r_overflow;
  logic              r_underflow;

  // NORM stage combinational values
  logic              w_zero;
  logic [22:0]       w_norm_frac;
  logic              w_norm_guard;
  logic              w_norm_sticky;
  logic signed [9:0] w_norm_e;

  // ROUND stage combinational values
  logic              w_round_up;
  logic [23:0]       w_frac_inc;

  // PACK stage combinational values
  logic [31:0]       w_pack_result;
  logic              w_pack_ovf;
  logic              w_pack_unf;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_next = StNorm;
      StNorm:  w_state_next = StRound;
      StRound: w_state_next = StPack;
      StPack:  w_state_next = StOut;
      StOut:   if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Normalization: a product of two [1,2) mantissas lies in [1,4). If bit 47
  // is set the value is in [2,4) and needs a one-place right shift, which
  // bumps the exponent by one.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_zero = (r_mant[47:46] == 2'b00);
    if (r_mant[47]) begin
      w_norm_frac   = r_mant[46:24];
      w_norm_guard  = r_mant[23];
      w_norm_sticky = |r_mant[22:0];
    end else begin
      w_norm_frac   = r_mant[45:23];
      w_norm_guard  = r_mant[22];
      w_norm_sticky = |r_mant[21:0];
    end
    // exp_sum is zero-extended; the 10-bit result covers -127..385.
    w_norm_e = {1'b0, r_exp_sum} - 10'd127 + {9'd0, r_mant[47]};
  end

  // ---------------------------------------------------------------------------
  // Rounding: nearest, ties to even. A carry out of the fraction means the
  // mantissa became 2.0, i.e. frac wraps to zero and the exponent goes up.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_round_up = r_guard & (r_sticky | r_frac[0]);
    w_frac_inc = {1'b0, r_frac} + {23'd0, w_round_up};
  end

  // ---------------------------------------------------------------------------
  // Packing, in priority order: zero, overflow, underflow, normal.
  // No subnormals are produced; anything at or below exponent 0 flushes.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pack_result = {r_sign, r_e[7:0], r_frac};
    w_pack_ovf    = 1'b0;
    w_pack_unf    = 1'b0;
    if (r_zero) begin
      w_pack_result = {r_sign, 31'd0};
    end else if (r_e >= 10'sd255) begin
      w_pack_result = {r_sign, 8'hFF, 23'd0};
      w_pack_ovf    = 1'b1;
    end else if (r_e <= 10'sd0) begin
      w_pack_result = {r_sign, 31'd0};
      w_pack_unf    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_sign      <= 1'b0;
      r_exp_sum   <= 9'd0;
      r_mant      <= 48'd0;
      r_zero      <= 1'b0;
      r_frac      <= 23'd0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_e         <= 10'sd0;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sign    <= sign_in;
            r_exp_sum <= exp_sum;
            r_mant    <= mant_prod;
          end
        end
        StNorm: begin
          r_zero   <= w_zero;
          r_frac   <= w_norm_frac;
          r_guard  <= w_norm_guard;
          r_sticky <= w_norm_sticky;
          r_e      <= w_norm_e;
        end
        StRound: begin
          r_frac <= w_frac_inc[22:0];
          if (w_frac_inc[23]) r_e <= r_e + 10'sd1;
        end
        StPack: begin
          // Result and flags change together, only here.
          r_result    <= w_pack_result;
          r_overflow  <= w_pack_ovf;
          r_underflow <= w_pack_unf;
          r_out_valid <= 1'b1;
        end
        StOut: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_norm_round.sv
// Self-checking bench for norm_round: a value-level reference model (plain
// integer arithmetic on the mantissa) plus a transaction-level expectation of
// handshake timing, checked on every falling clock edge.
module tb_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [8:0]  exp_sum;
  logic [47:0] mant_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_sum   (exp_sum),
    .mant_prod (mant_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {overflow, underflow, result}.
  function automatic logic [33:0] model(input logic s, input logic [8:0] es,
                                        input logic [47:0] p);
    longint unsigned pp, m, rem, half;
    int e;
    int sh;
    if (p[47:46] == 2'b00) return {2'b00, s, 31'd0};
    pp   = 64'(p);
    sh   = p[47] ? 24 : 23;
    e    = int'(es) - 127 + (p[47] ? 1 : 0);
    m    = pp >> sh;
    rem  = pp & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  // Transaction-level expectation state
  logic [33:0] exp_q[$];
  logic        m_busy = 1'b0;
  int          m_cyc  = 0;
  int          m_acc  = 0;

  // Model of acceptance and handshake, evaluated at each rising edge.
  initial begin
    logic ov_prev;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else begin
        ov_prev = m_busy && (m_cyc - m_acc >= 3);
        m_cyc++;
        if (ov_prev && out_ready) begin
          m_busy = 1'b0;
          void'(exp_q.pop_front());
        end else if (!m_busy && in_valid) begin
          m_busy = 1'b1;
          m_acc  = m_cyc;
          exp_q.push_back(model(sign_in, exp_sum, mant_prod));
        end
      end
    end
  end

  // Compare process: every falling edge.
  initial begin
    logic exp_ov;
    forever begin
      @(negedge clk);
      exp_ov = m_busy && (m_cyc - m_acc >= 3);
      chk("in_ready", 34'(in_ready), 34'(!m_busy));
      chk("out_valid", 34'(out_valid), 34'(exp_ov));
      if (out_valid && exp_ov && exp_q.size() > 0)
        chk("result_flags", {overflow, underflow, result}, exp_q[0]);
    end
  end

  // Directed single operation; leaves the bench 1 time unit after a rising edge.
  task automatic do_op(input logic s, input logic [8:0] e, input logic [47:0] p);
    sign_in   = s;
    exp_sum   = e;
    mant_prod = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] gen_p();
    logic [63:0] r;
    logic [47:0] a, b;
    r = {$urandom, $urandom};
    case ($urandom % 8)
      0: return {2'b00, r[45:0]};
      1: return {1'b1, r[22:0], 1'b1, 23'd0};
      2: return {2'b01, r[22:0], 1'b1, 22'd0};
      3: return {2'b01, 23'h7FFFFF, r[22:0]};
      default: begin
        a = {24'd0, 1'b1, r[22:0]};
        b = {24'd0, 1'b1, r[45:23]};
        return a * b;
      end
    endcase
  endfunction

  function automatic logic [8:0] gen_e();
    case ($urandom % 4)
      0: return 9'($urandom % 512);
      1: return 9'($urandom_range(120, 135));
      2: return 9'($urandom_range(375, 386));
      default: return 9'($urandom_range(140, 370));
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_sum   = 9'd0;
    mant_prod = 48'd0;

    // Pin the reference model with hand-computed values.
    chk("pin_identity", model(1'b0, 9'd254, 48'h4000_0000_0000), {2'b00, 32'h3F80_0000});
    chk("pin_shift",    model(1'b0, 9'd254, 48'h9000_0000_0000), {2'b00, 32'h4010_0000});
    chk("pin_tie_odd",  model(1'b0, 9'd254, 48'h4000_00C0_0000), {2'b00, 32'h3F80_0002});
    chk("pin_tie_even", model(1'b0, 9'd254, 48'h4000_0040_0000), {2'b00, 32'h3F80_0000});
    chk("pin_carry",    model(1'b0, 9'd254, 48'h7FFF_FFC0_0000), {2'b00, 32'h4000_0000});
    chk("pin_ovf",      model(1'b0, 9'd383, 48'h4000_0000_0000), {2'b10, 32'h7F80_0000});
    chk("pin_unf",      model(1'b1, 9'd100, 48'h4000_0000_0000), {2'b01, 32'h8000_0000});
    chk("pin_zero",     model(1'b1, 9'd254, 48'h0),              {2'b00, 32'h8000_0000});

    #2;
    chk("rst_in_ready",  34'(in_ready),  34'd1);
    chk("rst_out_valid", 34'(out_valid), 34'd0);
    chk("rst_result",    {overflow, underflow, result}, 34'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    do_op(1'b0, 9'd254, 48'h4000_0000_0000);
    do_op(1'b0, 9'd254, 48'h9000_0000_0000);
    do_op(1'b0, 9'd254, 48'h4000_00C0_0000);
    do_op(1'b0, 9'd254, 48'h4000_0040_0000);
    do_op(1'b0, 9'd254, 48'h7FFF_FFC0_0000);
    do_op(1'b0, 9'd383, 48'h4000_0000_0000);
    do_op(1'b1, 9'd100, 48'h4000_0000_0000);
    do_op(1'b0, 9'd254, 48'h0);
    do_op(1'b1, 9'd254, 48'h0);
    do_op(1'b0, 9'd127, 48'h4000_0000_0000);
    do_op(1'b0, 9'd381, 48'h7FFF_FFC0_0000);

    // Backpressure: result held while in_valid pulses with other operands.
    sign_in   = 1'b1;
    exp_sum   = 9'd200;
    mant_prod = 48'h9000_0000_0000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = i[0];
      sign_in   = 1'b0;
      exp_sum   = 9'd300;
      mant_prod = 48'h7FFF_FFFF_FFFF;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 9'd260, 48'hB000_0000_1234);

    // Reset while the operation sits in ROUND.
    sign_in   = 1'b0;
    exp_sum   = 9'd254;
    mant_prod = 48'h4000_0000_0000;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 34'(out_valid), 34'd0);
    chk("midrst_result",    34'(result),    34'd0);
    chk("midrst_in_ready",  34'(in_ready),  34'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom % 3) != 0;
      sign_in   = 1'($urandom);
      exp_sum   = gen_e();
      mant_prod = gen_p();
      out_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_queue", 34'(exp_q.size()), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
